// File: rtl/sat_run_sequencer.sv
// sat_run_sequencer: sequences one CNF evaluation on the SAT accelerator array.
// The host loads {eoc,neg,var} literals into a persistent buffer. A start pulse
// replays the buffer as GLOBAL_RST / LIT... / COMMIT / CLAUSE_RST command
// groups, waits RES_LAT cycles for the array result, latches it into sat and
// pulses done.
// Optional build macro: SAT_SEQ_CYCLE_CNT_EN adds the run_cycles[15:0] output.
module sat_run_sequencer #(
    parameter int unsigned LIT_DEPTH = 64,
    parameter int unsigned RES_LAT   = 3,
    parameter int unsigned VAR_W     = 5
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             lit_valid,
    output logic             lit_ready,
    input  logic [VAR_W-1:0] lit_var,
    input  logic             lit_neg,
    input  logic             lit_eoc,
    input  logic             clr,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             sat,
    output logic             err,
    output logic [1:0]       stateVal,
    output logic [VAR_W-1:0] varPos,
    output logic             negCtrl,
    input  logic             outSATRes
`ifdef SAT_SEQ_CYCLE_CNT_EN
    ,
    output logic [15:0]      run_cycles
`endif
);

    localparam int unsigned AW = (LIT_DEPTH > 1) ? $clog2(LIT_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;

    localparam logic [CW-1:0] DEPTH_C    = CW'(LIT_DEPTH);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(RES_LAT - 1);

    localparam logic [1:0] CMD_GRST   = 2'b00;
    localparam logic [1:0] CMD_CRST   = 2'b01;
    localparam logic [1:0] CMD_LIT    = 2'b10;
    localparam logic [1:0] CMD_COMMIT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRST,
        S_LIT,
        S_COMMIT,
        S_CRST,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic             eoc;
        logic             neg;
        logic [VAR_W-1:0] vpos;
    } lit_t;

    lit_t             r_mem [LIT_DEPTH];

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    r_ptr;
    logic [DW-1:0]    r_drain;
    logic             r_clause_end;
    logic             r_last;
    logic             r_lit_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_sat;
    logic             r_err;
    logic [1:0]       r_stateVal;
    logic [VAR_W-1:0] r_varPos;
    logic             r_negCtrl;

    logic             w_start_ok;
    logic             w_clr_ok;
    logic             w_wr;
    logic             w_final;
    logic [CW-1:0]    w_cnt_nxt;
    lit_t             w_rd;
    lit_t             w_wr_lit;

    // Host-side load qualifiers: start beats clr, clr beats a same-cycle write
    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_clr_ok   = (r_state == S_IDLE) && clr && !start;
    assign w_wr       = lit_valid && r_lit_ready && !w_clr_ok;
    assign w_wr_lit   = '{eoc: lit_eoc, neg: lit_neg, vpos: lit_var};

    // Replay read port and "this is the last buffered entry" flag
    assign w_rd    = r_mem[r_ptr];
    assign w_final = ({1'b0, r_ptr} == (r_count - CW'(1)));

    // Next buffer fill level
    always_comb begin
        w_cnt_nxt = r_count;
        if (w_clr_ok) begin
            w_cnt_nxt = '0;
        end else if (w_wr) begin
            w_cnt_nxt = r_count + CW'(1);
        end
    end

    // Literal buffer storage; contents survive runs, only the count is cleared
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_count[AW-1:0]] <= w_wr_lit;
        end
    end

    // Run sequencer FSM with registered command and handshake outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_ptr        <= '0;
            r_drain      <= '0;
            r_clause_end <= 1'b0;
            r_last       <= 1'b0;
            r_lit_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sat        <= 1'b0;
            r_err        <= 1'b0;
            r_stateVal   <= CMD_CRST;
            r_varPos     <= '0;
            r_negCtrl    <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_lit_ready <= 1'b0;
            r_count     <= w_cnt_nxt;
            if (abort && r_busy) begin
                r_state     <= S_IDLE;
                r_stateVal  <= CMD_CRST;
                r_varPos    <= '0;
                r_negCtrl   <= 1'b0;
                r_busy      <= 1'b0;
                r_lit_ready <= (r_count < DEPTH_C);
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_ok) begin
                            if (r_count == '0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_err   <= 1'b1;
                                r_sat   <= 1'b0;
                            end else begin
                                r_state    <= S_GRST;
                                r_stateVal <= CMD_GRST;
                                r_err      <= 1'b0;
                                r_ptr      <= '0;
                                r_busy     <= 1'b1;
                            end
                        end else begin
                            r_lit_ready <= (w_cnt_nxt < DEPTH_C);
                        end
                    end
                    S_GRST, S_CRST, S_LIT: begin
                        if ((r_state == S_LIT) && r_clause_end) begin
                            r_state    <= S_COMMIT;
                            r_stateVal <= CMD_COMMIT;
                            r_varPos   <= '0;
                            r_negCtrl  <= 1'b0;
                        end else begin
                            r_state      <= S_LIT;
                            r_stateVal   <= CMD_LIT;
                            r_varPos     <= w_rd.vpos;
                            r_negCtrl    <= w_rd.neg;
                            r_ptr        <= r_ptr + AW'(1);
                            r_clause_end <= w_rd.eoc || w_final;
                            r_last       <= w_final;
                        end
                    end
                    S_COMMIT: begin
                        r_stateVal <= CMD_CRST;
                        if (r_last) begin
                            r_state <= S_DRAIN;
                            r_drain <= DRAIN_INIT;
                        end else begin
                            r_state <= S_CRST;
                        end
                    end
                    S_DRAIN: begin
                        if (r_drain == '0) begin
                            r_sat   <= outSATRes;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_drain <= r_drain - DW'(1);
                        end
                    end
                    S_DONE: begin
                        r_state     <= S_IDLE;
                        r_lit_ready <= (r_count < DEPTH_C);
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_stateVal <= CMD_CRST;
                        r_busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign lit_ready = r_lit_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sat       = r_sat;
    assign err       = r_err;
    assign stateVal  = r_stateVal;
    assign varPos    = r_varPos;
    assign negCtrl   = r_negCtrl;

`ifdef SAT_SEQ_CYCLE_CNT_EN
    logic [15:0] r_run_cycles;

    // Busy-cycle counter: cleared on accepted start, saturates, holds when idle
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_run_cycles <= '0;
        end else if (w_start_ok) begin
            r_run_cycles <= '0;
        end else if (r_busy && (r_run_cycles != 16'hFFFF)) begin
            r_run_cycles <= r_run_cycles + 16'd1;
        end
    end

    assign run_cycles = r_run_cycles;
`endif

endmodule

// File: tb/tb_sat_run_sequencer.sv
// Self-checking bench for sat_run_sequencer: directed scenarios plus randomized
// formulas, compared against a command-stream model built from the buffer list.
module tb_sat_run_sequencer;

    localparam int DEPTH = 16;
    localparam int RL    = 3;
    localparam int VW    = 5;

    typedef struct packed {
        logic          eoc;
        logic          neg;
        logic [VW-1:0] vpos;
    } tl_t;

    logic          clk = 1'b0;
    logic          resetN;
    logic          lit_valid;
    logic          lit_ready;
    logic [VW-1:0] lit_var;
    logic          lit_neg;
    logic          lit_eoc;
    logic          clr;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          sat;
    logic          err;
    logic [1:0]    stateVal;
    logic [VW-1:0] varPos;
    logic          negCtrl;
    logic          outSATRes;
`ifdef SAT_SEQ_CYCLE_CNT_EN
    logic [15:0]   run_cycles;
`endif

    sat_run_sequencer #(.LIT_DEPTH(DEPTH), .RES_LAT(RL), .VAR_W(VW)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .lit_valid (lit_valid),
        .lit_ready (lit_ready),
        .lit_var   (lit_var),
        .lit_neg   (lit_neg),
        .lit_eoc   (lit_eoc),
        .clr       (clr),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .sat       (sat),
        .err       (err),
        .stateVal  (stateVal),
        .varPos    (varPos),
        .negCtrl   (negCtrl),
        .outSATRes (outSATRes)
`ifdef SAT_SEQ_CYCLE_CNT_EN
        ,
        .run_cycles(run_cycles)
`endif
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    tl_t  mbuf [$];
    logic [1:0]    q_sv [$];
    logic [VW-1:0] q_vp [$];
    logic          q_ng [$];
    logic m_sat = 1'b0;
    logic m_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected array command stream for the current buffer contents
    task automatic build_seq();
        int last;
        last = mbuf.size() - 1;
        q_sv.delete(); q_vp.delete(); q_ng.delete();
        q_sv.push_back(2'b00); q_vp.push_back('0); q_ng.push_back(1'b0);
        for (int i = 0; i <= last; i++) begin
            q_sv.push_back(2'b10); q_vp.push_back(mbuf[i].vpos); q_ng.push_back(mbuf[i].neg);
            if (mbuf[i].eoc || i == last) begin
                q_sv.push_back(2'b11); q_vp.push_back('0); q_ng.push_back(1'b0);
                if (i != last) begin
                    q_sv.push_back(2'b01); q_vp.push_back('0); q_ng.push_back(1'b0);
                end
            end
        end
        for (int i = 0; i < RL; i++) begin
            q_sv.push_back(2'b01); q_vp.push_back('0); q_ng.push_back(1'b0);
        end
    endtask

    task automatic wr_lit(input logic [VW-1:0] v, input logic n, input logic e);
        logic exp_rdy;
        exp_rdy = (mbuf.size() < DEPTH);
        chk("lit_ready", 32'(lit_ready), 32'(exp_rdy));
        lit_valid = 1'b1; lit_var = v; lit_neg = n; lit_eoc = e;
        @(negedge clk);
        lit_valid = 1'b0;
        if (exp_rdy) mbuf.push_back('{eoc: e, neg: n, vpos: v});
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        mbuf.delete();
        chk("lit_ready_after_clr", 32'(lit_ready), 32'd1);
    endtask

    task automatic load_t1();
        wr_lit(5'd0, 1'b0, 1'b0);
        wr_lit(5'd1, 1'b1, 1'b1);
        wr_lit(5'd2, 1'b0, 1'b0);
        wr_lit(5'd3, 1'b0, 1'b1);
    endtask

    // One run from start; abort_at<0 runs to completion, force_res<0 randomizes outSATRes
    task automatic run_seq(input int abort_at, input int force_res);
        int   n;
        logic res;
        build_seq();
        n = q_sv.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("busy[%0d]", k), 32'(busy), 32'd1);
            chk($sformatf("stateVal[%0d]", k), 32'(stateVal), 32'(q_sv[k]));
            if (q_sv[k] == 2'b10) begin
                chk($sformatf("varPos[%0d]", k), 32'(varPos), 32'(q_vp[k]));
                chk($sformatf("negCtrl[%0d]", k), 32'(negCtrl), 32'(q_ng[k]));
            end
            chk($sformatf("done_run[%0d]", k), 32'(done), 32'd0);
            if (k == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_stateVal", 32'(stateVal), 32'd1);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_sat", 32'(sat), 32'(m_sat));
                @(negedge clk);
                chk("abort_done2", 32'(done), 32'd0);
                chk("abort_lit_ready", 32'(lit_ready), 32'(mbuf.size() < DEPTH));
                return;
            end
            res = (force_res < 0) ? 1'($urandom % 2) : 1'(force_res);
            outSATRes = res;
            @(negedge clk);
            if (k == n - 1) m_sat = res;
        end
        m_err = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("sat", 32'(sat), 32'(m_sat));
        chk("err", 32'(err), 32'd0);
        chk("done_stateVal", 32'(stateVal), 32'd1);
`ifdef SAT_SEQ_CYCLE_CNT_EN
        chk("run_cycles", 32'(run_cycles), 32'(n));
`endif
        @(negedge clk);
        chk("done_end", 32'(done), 32'd0);
        chk("sat_hold", 32'(sat), 32'(m_sat));
        chk("idle_lit_ready", 32'(lit_ready), 32'(mbuf.size() < DEPTH));
`ifdef SAT_SEQ_CYCLE_CNT_EN
        chk("run_cycles_hold", 32'(run_cycles), 32'(n));
`endif
    endtask

    task automatic empty_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_err = 1'b1; m_sat = 1'b0;
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_err", 32'(err), 32'd1);
        chk("empty_sat", 32'(sat), 32'd0);
        chk("empty_busy", 32'(busy), 32'd0);
        chk("empty_stateVal", 32'(stateVal), 32'd1);
        @(negedge clk);
        chk("empty_done_end", 32'(done), 32'd0);
        chk("empty_err_hold", 32'(err), 32'd1);
        chk("empty_busy2", 32'(busy), 32'd0);
        chk("empty_stateVal2", 32'(stateVal), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        resetN = 1'b0; lit_valid = 1'b0; lit_var = '0; lit_neg = 1'b0; lit_eoc = 1'b0;
        clr = 1'b0; start = 1'b0; abort = 1'b0; outSATRes = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_lit_ready", 32'(lit_ready), 32'd0);
        chk("rst_stateVal", 32'(stateVal), 32'd1);
        chk("rst_varPos", 32'(varPos), 32'd0);
        chk("rst_negCtrl", 32'(negCtrl), 32'd0);
        resetN = 1'b1;
        repeat (2) @(negedge clk);

        // Directed two-clause formula, result forced high
        load_t1();
        run_seq(-1, 1);
        // Abort in the LIT phase, then replay the retained buffer
        run_seq(2, -1);
        run_seq(-1, -1);

        // Empty buffer start
        do_clr();
        empty_start();

        // clr and a write in the same cycle: buffer ends empty
        clr = 1'b1; lit_valid = 1'b1; lit_var = 5'd7;
        @(negedge clk);
        clr = 1'b0; lit_valid = 1'b0;
        mbuf.delete();
        empty_start();

        // Fill to capacity with no eoc, overflow write dropped
        for (int i = 0; i < DEPTH; i++) wr_lit(5'($urandom), 1'($urandom), 1'b0);
        chk("full_lit_ready", 32'(lit_ready), 32'd0);
        wr_lit(5'd31, 1'b1, 1'b1);
        run_seq(-1, -1);

        // Randomized formulas, each run then replayed
        for (int r = 0; r < 6; r++) begin
            int len;
            do_clr();
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++)
                wr_lit(5'($urandom), 1'($urandom), 1'(($urandom % 4) == 0));
            run_seq(-1, -1);
            if (r % 2 == 1) run_seq($urandom_range(1, 4), -1);
            run_seq(-1, -1);
        end

        // Reset in the middle of DRAIN
        do_clr();
        load_t1();
        build_seq();
        n = q_sv.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (n - 2) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        resetN = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sat", 32'(sat), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_lit_ready", 32'(lit_ready), 32'd0);
        chk("midrst_stateVal", 32'(stateVal), 32'd1);
        chk("midrst_varPos", 32'(varPos), 32'd0);
        chk("midrst_negCtrl", 32'(negCtrl), 32'd0);
        mbuf.delete(); m_sat = 1'b0; m_err = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_lit_ready", 32'(lit_ready), 32'd1);
        empty_start();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
